// File: rtl/stream_sorter_pkg.sv
// Shared types and helpers for the serial odd-even transposition sorter.
package stream_sorter_pkg;

    typedef enum logic [1:0] {LOAD, SORT, DRAIN} state_e;

    // Counter width for indices 0..n-1, never narrower than one bit.
    function automatic int cnt_width(input int n);
        return (n <= 2) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/stream_sorter_cmp_swap.sv
// Combinational compare-exchange: lo/hi land in the lower/upper buffer slot.
module cmp_swap #(
    parameter int DATA_W  = 4,
    parameter bit DESCEND = 1'b0
) (
    input  logic [DATA_W-1:0] a,
    input  logic [DATA_W-1:0] b,
    input  logic              en,
    output logic [DATA_W-1:0] lo,
    output logic [DATA_W-1:0] hi
);

    logic swap;

    // Strict compare keeps equal words in place.
    assign swap = en && (DESCEND ? (a < b) : (a > b));
    assign lo   = swap ? b : a;
    assign hi   = swap ? a : b;

endmodule

// File: rtl/stream_sorter.sv
// Serial-in / serial-out frame sorter: load DATA_N words, DATA_N transposition phases, drain.
module stream_sorter
    import stream_sorter_pkg::*;
#(
    parameter int DATA_N  = 4,
    parameter int DATA_W  = 4,
    parameter bit DESCEND = 1'b0
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [DATA_W-1:0] in_data,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [DATA_W-1:0] out_data,
    output logic              out_last,
    output logic              busy
);

    localparam int CW    = cnt_width(DATA_N);
    localparam int NE    = DATA_N / 2;
    localparam int NO    = (DATA_N - 1) / 2;
    localparam int NO_SZ = (NO > 0) ? NO : 1;
    localparam logic [CW-1:0] LAST = CW'(DATA_N - 1);

    typedef logic [DATA_N-1:0][DATA_W-1:0] mem_t;

    state_e            state_q, state_d;
    logic [CW-1:0]     idx_q, idx_d, phase_q, phase_d, idx_nxt;
    mem_t              mem_q, mem_d, even_mem, odd_mem, sorted_mem;
    logic              out_valid_q, out_valid_d, out_last_q, out_last_d;
    logic [DATA_W-1:0] out_data_q, out_data_d;
    logic              sort_even, sort_odd;

    logic [DATA_W-1:0] ev_lo [NE];
    logic [DATA_W-1:0] ev_hi [NE];
    logic [DATA_W-1:0] od_lo [NO_SZ];
    logic [DATA_W-1:0] od_hi [NO_SZ];

    assign sort_even = (state_q == SORT) && !phase_q[0];
    assign sort_odd  = (state_q == SORT) &&  phase_q[0];

    for (genvar g = 0; g < NE; g++) begin : g_even
        cmp_swap #(.DATA_W(DATA_W), .DESCEND(DESCEND)) u_cs (
            .a(mem_q[2*g]), .b(mem_q[2*g+1]), .en(sort_even),
            .lo(ev_lo[g]), .hi(ev_hi[g])
        );
    end

    if (NO > 0) begin : g_odd_on
        for (genvar g = 0; g < NO; g++) begin : g_odd
            cmp_swap #(.DATA_W(DATA_W), .DESCEND(DESCEND)) u_cs (
                .a(mem_q[2*g+1]), .b(mem_q[2*g+2]), .en(sort_odd),
                .lo(od_lo[g]), .hi(od_hi[g])
            );
        end
    end else begin : g_odd_off
        assign od_lo[0] = '0;
        assign od_hi[0] = '0;
    end

    // Slots not covered by a pair (ends in odd phases, odd DATA_N) pass through.
    always_comb begin
        even_mem = mem_q;
        odd_mem  = mem_q;
        for (int i = 0; i < NE; i++) begin
            even_mem[2*i]   = ev_lo[i];
            even_mem[2*i+1] = ev_hi[i];
        end
        for (int i = 0; i < NO; i++) begin
            odd_mem[2*i+1] = od_lo[i];
            odd_mem[2*i+2] = od_hi[i];
        end
        sorted_mem = phase_q[0] ? odd_mem : even_mem;
    end

    assign idx_nxt = idx_q + CW'(1);

    always_comb begin
        state_d     = state_q;
        idx_d       = idx_q;
        phase_d     = phase_q;
        mem_d       = mem_q;
        out_valid_d = out_valid_q;
        out_data_d  = out_data_q;
        out_last_d  = out_last_q;
        unique case (state_q)
            LOAD: begin
                if (in_valid) begin
                    mem_d[idx_q] = in_data;
                    if (idx_q == LAST) begin
                        state_d = SORT;
                        idx_d   = '0;
                        phase_d = '0;
                    end else begin
                        idx_d = idx_nxt;
                    end
                end
            end
            SORT: begin
                mem_d = sorted_mem;
                if (phase_q == LAST) begin
                    state_d     = DRAIN;
                    phase_d     = '0;
                    idx_d       = '0;
                    out_valid_d = 1'b1;
                    out_data_d  = sorted_mem[0];
                    out_last_d  = 1'b0;
                end else begin
                    phase_d = phase_q + CW'(1);
                end
            end
            DRAIN: begin
                if (out_ready) begin
                    if (out_last_q) begin
                        state_d     = LOAD;
                        idx_d       = '0;
                        out_valid_d = 1'b0;
                        out_last_d  = 1'b0;
                    end else begin
                        idx_d      = idx_nxt;
                        out_data_d = mem_q[idx_nxt];
                        out_last_d = (idx_nxt == LAST);
                    end
                end
            end
            default: state_d = LOAD;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= LOAD;
            idx_q       <= '0;
            phase_q     <= '0;
            mem_q       <= '0;
            out_valid_q <= 1'b0;
            out_data_q  <= '0;
            out_last_q  <= 1'b0;
        end else begin
            state_q     <= state_d;
            idx_q       <= idx_d;
            phase_q     <= phase_d;
            mem_q       <= mem_d;
            out_valid_q <= out_valid_d;
            out_data_q  <= out_data_d;
            out_last_q  <= out_last_d;
        end
    end

    assign in_ready  = (state_q == LOAD);
    assign busy      = (state_q != LOAD);
    assign out_valid = out_valid_q;
    assign out_data  = out_data_q;
    assign out_last  = out_last_q;

endmodule

// File: tb/tb_stream_sorter.sv
// Randomized and directed bench for stream_sorter over three parameterizations.
module tb_stream_sorter;

    localparam int NS [3] = '{4, 4, 5};
    localparam int DS [3] = '{0, 1, 0};

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       iv_a [3];
    logic       ir_a [3];
    logic [3:0] id_a [3];
    logic       ov_a [3];
    logic       or_a [3];
    logic [3:0] od_a [3];
    logic       ol_a [3];
    logic       bz_a [3];

    int checks = 0;
    int errors = 0;
    int cyc = 0;

    int inq   [3][$];
    int exp_q [3][$];
    int got_q [3][$];
    bit exp_busy [3];
    int cnt      [3];
    int acc_cyc  [3];
    int lat      [3];
    bit seen_ov  [3];

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    stream_sorter #(.DATA_N(4), .DATA_W(4), .DESCEND(1'b0)) u_dut0 (
        .clk(clk), .rst_n(rst_n), .in_valid(iv_a[0]), .in_ready(ir_a[0]), .in_data(id_a[0]),
        .out_valid(ov_a[0]), .out_ready(or_a[0]), .out_data(od_a[0]), .out_last(ol_a[0]), .busy(bz_a[0]));
    stream_sorter #(.DATA_N(4), .DATA_W(4), .DESCEND(1'b1)) u_dut1 (
        .clk(clk), .rst_n(rst_n), .in_valid(iv_a[1]), .in_ready(ir_a[1]), .in_data(id_a[1]),
        .out_valid(ov_a[1]), .out_ready(or_a[1]), .out_data(od_a[1]), .out_last(ol_a[1]), .busy(bz_a[1]));
    stream_sorter #(.DATA_N(5), .DATA_W(4), .DESCEND(1'b0)) u_dut2 (
        .clk(clk), .rst_n(rst_n), .in_valid(iv_a[2]), .in_ready(ir_a[2]), .in_data(id_a[2]),
        .out_valid(ov_a[2]), .out_ready(or_a[2]), .out_data(od_a[2]), .out_last(ol_a[2]), .busy(bz_a[2]));

    task automatic chk(input string nm, input int k, input int act, input int expv);
        checks++;
        if (act != expv) begin
            errors++;
            $display("FAIL %s[%0d] got %0d expected %0d (t=%0t)", nm, k, act, expv, $time);
        end
    endtask

    // Reference: a completed frame is simply the stable sort of its words.
    function automatic void push_sorted(input int k);
        int a[$];
        int t;
        a = inq[k];
        for (int i = 1; i < a.size(); i++)
            for (int j = i; j > 0; j--)
                if ((DS[k] != 0) ? (a[j] > a[j-1]) : (a[j] < a[j-1])) begin
                    t = a[j]; a[j] = a[j-1]; a[j-1] = t;
                end
        foreach (a[i]) exp_q[k].push_back(a[i]);
        inq[k].delete();
    endfunction

    always @(negedge clk) begin
        for (int k = 0; k < 3; k++) begin
            if (!rst_n) begin
                inq[k].delete(); exp_q[k].delete();
                exp_busy[k] = 1'b0; cnt[k] = 0;
                chk("rst_ov", k, int'(ov_a[k]), 0);
                chk("rst_od", k, int'(od_a[k]), 0);
                chk("rst_last", k, int'(ol_a[k]), 0);
                chk("rst_ir", k, int'(ir_a[k]), 1);
                chk("rst_busy", k, int'(bz_a[k]), 0);
            end else begin
                bit eb, eov, xin, xout;
                eb  = exp_busy[k];
                eov = eb && (cnt[k] >= NS[k]);
                chk("out_valid", k, int'(ov_a[k]), int'(eov));
                chk("in_ready", k, int'(ir_a[k]), int'(!eb));
                chk("busy", k, int'(bz_a[k]), int'(eb));
                if (eov && exp_q[k].size() > 0) begin
                    chk("out_data", k, int'(od_a[k]), exp_q[k][0]);
                    chk("out_last", k, int'(ol_a[k]), int'(exp_q[k].size() == 1));
                end
                if (ov_a[k] && !seen_ov[k]) begin
                    seen_ov[k] = 1'b1;
                    lat[k] = cyc - acc_cyc[k];
                end
                xin  = iv_a[k] && !eb;
                xout = eov && or_a[k];
                if (eb) cnt[k]++;
                if (xout && exp_q[k].size() > 0) begin
                    got_q[k].push_back(int'(od_a[k]));
                    void'(exp_q[k].pop_front());
                    if (exp_q[k].size() == 0) exp_busy[k] = 1'b0;
                end
                if (xin) begin
                    inq[k].push_back(int'(id_a[k]));
                    if (inq[k].size() == NS[k]) begin
                        push_sorted(k);
                        exp_busy[k] = 1'b1; cnt[k] = 0;
                        acc_cyc[k] = cyc; seen_ov[k] = 1'b0;
                    end
                end
            end
        end
    end

    task automatic drive_in(input int k, input int w[$], input int gaps[$]);
        bit acc;
        foreach (w[i]) begin
            iv_a[k] = 1'b0;
            if (i < gaps.size()) repeat (gaps[i]) begin @(posedge clk); #1; end
            iv_a[k] = 1'b1;
            id_a[k] = 4'(w[i]);
            acc = 1'b0;
            for (int c = 0; c < 200 && !acc; c++) begin
                @(negedge clk); acc = ir_a[k];
                @(posedge clk); #1;
            end
            if (!acc) chk("in_timeout", k, 0, 1);
        end
        iv_a[k] = 1'b0;
    endtask

    task automatic drive_out(input int k, input int pat[$]);
        bit seen = 1'b0;
        for (int c = 0; c < 200 && !seen; c++) begin
            @(posedge clk); #1; seen = ov_a[k];
        end
        if (!seen) chk("ov_timeout", k, 0, 1);
        foreach (pat[i]) begin
            or_a[k] = pat[i][0];
            @(posedge clk); #1;
        end
        or_a[k] = 1'b1;
    endtask

    task automatic wait_idle(input int k);
        for (int c = 0; c < 200; c++) begin
            if (exp_q[k].size() == 0 && !exp_busy[k] && inq[k].size() == 0) return;
            @(posedge clk); #1;
        end
        chk("idle_timeout", k, 0, 1);
    endtask

    task automatic run_frame(input int k, input int w[$], input int gaps[$], input int pat[$]);
        fork
            drive_in(k, w, gaps);
            drive_out(k, pat);
        join
        wait_idle(k);
    endtask

    task automatic chk_got(input int k, input int lit[$]);
        chk("got_len", k, got_q[k].size(), lit.size());
        foreach (lit[i]) if (i < got_q[k].size()) chk("got_word", k, got_q[k][i], lit[i]);
        got_q[k].delete();
    endtask

    initial begin
        int w[$], g[$], p[$];
        for (int k = 0; k < 3; k++) begin
            iv_a[k] = 1'b0; id_a[k] = '0; or_a[k] = 1'b1;
        end
        repeat (3) @(posedge clk);
        #1 rst_n = 1'b1;
        @(posedge clk); #1;

        run_frame(0, '{3, 1, 2, 0}, '{}, '{});
        chk_got(0, '{0, 1, 2, 3});
        chk("lat4", 0, lat[0], 5);
        run_frame(0, '{15, 0, 15, 0}, '{}, '{});
        chk_got(0, '{0, 0, 15, 15});
        run_frame(0, '{0, 1, 2, 3}, '{}, '{});
        chk_got(0, '{0, 1, 2, 3});
        run_frame(0, '{3, 2, 1, 0}, '{}, '{});
        chk_got(0, '{0, 1, 2, 3});
        run_frame(0, '{9, 4, 7, 4}, '{}, '{1, 0, 0, 1, 1, 0, 1});
        chk_got(0, '{4, 4, 7, 9});

        run_frame(1, '{2, 8, 5, 1}, '{0, 1, 2, 0}, '{});
        chk_got(1, '{8, 5, 2, 1});

        // Abort a frame on its second sort cycle.
        drive_in(0, '{1, 2, 3, 0}, '{});
        @(posedge clk); #3;
        rst_n = 1'b0;
        #1;
        chk("async_ov", 0, int'(ov_a[0]), 0);
        chk("async_busy", 0, int'(bz_a[0]), 0);
        chk("async_ir", 0, int'(ir_a[0]), 1);
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
        got_q[0].delete();
        run_frame(0, '{6, 5, 4, 3}, '{}, '{});
        chk_got(0, '{3, 4, 5, 6});

        // Odd frame size with the next frame already waiting at the input.
        fork
            run_frame(2, '{4, 3, 2, 1, 0}, '{}, '{});
            begin
                for (int c = 0; c < 200 && !exp_busy[2]; c++) begin @(posedge clk); #1; end
                @(posedge clk); #2;
                drive_in(2, '{9, 7, 8, 6, 5}, '{});
            end
        join
        wait_idle(2);
        chk_got(2, '{0, 1, 2, 3, 4, 5, 6, 7, 8, 9});
        chk("lat5", 2, lat[2], 6);

        for (int r = 0; r < 30; r++) begin
            int k;
            k = r % 3;
            w.delete(); g.delete(); p.delete();
            for (int i = 0; i < NS[k]; i++) begin
                w.push_back(int'($urandom_range(0, 15)));
                g.push_back(($urandom_range(0, 3) == 0) ? int'($urandom_range(1, 2)) : 0);
            end
            for (int i = 0; i < 8; i++) p.push_back(int'($urandom_range(0, 1)));
            run_frame(k, w, g, p);
            got_q[k].delete();
        end

        repeat (2) @(posedge clk);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
